// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the fast-monitor spy-buffer readout path.
// Optional build macro used by fm_sb_rdout_arb: FM_SB_ARB_STATS_EN.
package fm_sb_pkg;

    // Spy buffer population: 27 L0MDT buffers plus 2 dummy slots.
    localparam int sb_mapped_n = 29;

    // Widest monitor payload carried on the FM link.
    localparam int mon_dw_max = 256;

    // One beat on the FM monitor link; fm_vld sits in bit 0 of the packed form.
    typedef struct packed {
        logic [mon_dw_max-1:0] fm_data;
        logic                  fm_vld;
    } fm_rt;

    // Default per-grant beat limit and idle revoke threshold.
    localparam int FM_SB_ARB_MAX_PKT = 64;
    localparam int FM_SB_ARB_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_XFER  = 2'd2
    } fm_sb_arb_state_t;

    // Next index after idx in a ring of n entries.
    function automatic int fm_sb_wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fm_rr_pick.sv
// Rotating-priority encoder: returns the first set request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module fm_rr_pick #(
    parameter int N_REQ = 29,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             found
);

    // Scan the ring starting at ptr and keep the first hit.
    always_comb begin
        int c;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= N_REQ) c = c - N_REQ;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fm_sb_rdout_arb.sv
// Packet-atomic round-robin arbiter sharing the FM monitor stream among the
// spy buffers. A grant is held until the packet ends, the beat limit forces a
// last beat, or the granted buffer stays idle for TIMEOUT cycles.
// Optional build macro: FM_SB_ARB_STATS_EN adds per-buffer packet counters.
module fm_sb_rdout_arb
    import fm_sb_pkg::*;
#(
    parameter int N_REQ         = sb_mapped_n,
    parameter int DW            = mon_dw_max,
    parameter int MAX_PKT_WORDS = FM_SB_ARB_MAX_PKT,
    parameter int TIMEOUT       = FM_SB_ARB_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [N_REQ-1:0]           sb_req,
    input  logic [N_REQ*DW-1:0]        sb_data,
    input  logic [N_REQ-1:0]           sb_vld,
    input  logic [N_REQ-1:0]           sb_last,
    output logic [N_REQ-1:0]           sb_rdy,
    output logic [$bits(fm_rt)-1:0]    fm_out,
    output logic                       fm_last,
    input  logic                       fm_rdy,
    output logic [$clog2(N_REQ)-1:0]   grant_idx,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       oversize_err
`ifdef FM_SB_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][15:0]     pkt_cnt
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_PKT_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    fm_sb_arb_state_t state, state_nxt;

    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] idle_cnt;

    // Granted requester's beat, selected by grant_idx.
    logic          g_vld;
    logic          g_last;
    logic [DW-1:0] g_data;

    logic out_free;
    logic accept;
    logic forced;
    logic pkt_end;
    logic to_hit;

    // Output register stage toward the monitor link.
    logic [DW-1:0] fm_data_p1;
    logic          fm_vld_p1;
    logic          fm_last_p1;

    fm_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (sb_req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign g_vld    = sb_vld[grant_idx];
    assign g_last   = sb_last[grant_idx];
    assign g_data   = sb_data[grant_idx*DW +: DW];
    assign out_free = !fm_vld_p1 || fm_rdy;
    assign forced   = (beat_cnt == BW'(MAX_PKT_WORDS - 1));

    // Next-state and handshake decode; only the granted buffer sees sb_rdy.
    always_comb begin
        state_nxt = state;
        sb_rdy    = '0;
        accept    = 1'b0;
        pkt_end   = 1'b0;
        to_hit    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (enable && |sb_req) state_nxt = ARB_GRANT;
            end
            ARB_GRANT: begin
                state_nxt = pick_found ? ARB_XFER : ARB_IDLE;
            end
            ARB_XFER: begin
                sb_rdy[grant_idx] = out_free;
                accept            = g_vld && out_free;
                if (accept) begin
                    pkt_end = g_last || forced;
                    if (pkt_end) state_nxt = ARB_IDLE;
                end else if (!g_vld && idle_cnt == TW'(TIMEOUT - 1)) begin
                    to_hit    = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    // Grant, pointer, beat/idle counters and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            grant_idx    <= '0;
            beat_cnt     <= '0;
            idle_cnt     <= '0;
            timeout_err  <= 1'b0;
            oversize_err <= 1'b0;
        end else begin
            timeout_err  <= to_hit;
            oversize_err <= accept && forced && !g_last;
            if (state == ARB_GRANT && pick_found) begin
                grant_idx <= pick_idx;
                beat_cnt  <= '0;
                idle_cnt  <= '0;
            end
            if (accept) begin
                idle_cnt <= '0;
                beat_cnt <= pkt_end ? '0 : beat_cnt + BW'(1);
            end else if (state == ARB_XFER && !g_vld) begin
                idle_cnt <= to_hit ? '0 : idle_cnt + TW'(1);
            end
            if (pkt_end || to_hit) begin
                ptr <= IW'(fm_sb_wrap_inc(int'(grant_idx), N_REQ));
            end
        end
    end

    // ---- stage p1: output beat register, holds while the link stalls ----
    always_ff @(posedge clk) begin
        if (rst) begin
            fm_data_p1 <= '0;
            fm_vld_p1  <= 1'b0;
            fm_last_p1 <= 1'b0;
        end else if (accept) begin
            fm_data_p1 <= g_data;
            fm_vld_p1  <= 1'b1;
            fm_last_p1 <= g_last || forced;
        end else if (fm_rdy) begin
            fm_vld_p1  <= 1'b0;
            fm_last_p1 <= 1'b0;
        end
    end

    assign fm_out  = {fm_data_p1, fm_vld_p1};
    assign fm_last = fm_last_p1 && fm_vld_p1;
    assign busy    = (state != ARB_IDLE);

`ifdef FM_SB_ARB_STATS_EN
    // Completed-packet count per buffer (natural or forced last), saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (pkt_end && pkt_cnt[grant_idx] != 16'hFFFF) begin
            pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fm_sb_rdout_arb.sv
// Bench for fm_sb_rdout_arb: per-buffer beat sources, a scoreboard of
// expected output beats, a table of single-source transfers and hand-written
// reset / round-robin / enable-drop / timeout sequences.
module tb_fm_sb_rdout_arb;
    import fm_sb_pkg::*;

    localparam int N    = sb_mapped_n;
    localparam int DW   = mon_dw_max;
    localparam int IW   = $clog2(N);
    localparam int MAXW = 64;
    localparam int TOUT = 1023;

    typedef logic [DW:0] v_t;

    logic clk = 1'b0;
    logic rst, enable, fm_rdy;
    logic [N-1:0] sb_req, sb_vld, sb_last, sb_rdy;
    logic [N*DW-1:0] sb_data;
    logic [DW:0] fm_out;
    logic fm_last, busy, timeout_err, oversize_err;
    logic [IW-1:0] grant_idx;
`ifdef FM_SB_ARB_STATS_EN
    logic [N-1:0][15:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    fm_sb_rdout_arb dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sb_req       (sb_req),
        .sb_data      (sb_data),
        .sb_vld       (sb_vld),
        .sb_last      (sb_last),
        .sb_rdy       (sb_rdy),
        .fm_out       (fm_out),
        .fm_last      (fm_last),
        .fm_rdy       (fm_rdy),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .oversize_err (oversize_err)
`ifdef FM_SB_ARB_STATS_EN
        ,
        .pkt_cnt      (pkt_cnt)
`endif
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            src;
    } exp_t;

    typedef struct {
        int src;
        int len;
        int md;
        int e_beats;
        int e_lasts;
        int e_ovs;
    } vec_t;

    exp_t expq[$];
    int   grant_log[$];

    int rem[N], plen[N], pos[N], seq[N], last_acc_cyc[N];
    logic [N-1:0] hold_req = '0;
    int mode = 0;
    int cyc = 0;
    int checks = 0, passed = 0;
    int beats_out = 0, lasts_out = 0, ovs_seen = 0, to_seen = 0;
    int to_cyc = 0;
    logic to_busy = 1'b1;
    int cur_src = -1, gcnt = 0;
    bit pkt_start = 1'b1;

    task automatic chk(input string nm, input v_t act, input v_t req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    function automatic logic [DW-1:0] mkdata(input int s, input int q);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = {s[7:0], k[7:0], q[15:0]};
        return r;
    endfunction

    // Sources and output monitor: drive at negedge, sample just after, book
    // accepted beats into the scoreboard after the posedge.
    initial begin : drv
        logic [N-1:0] acc;
        exp_t e;
        forever begin
            @(negedge clk);
            case (mode)
                0:       fm_rdy = 1'b1;
                1:       fm_rdy = (cyc % 2 == 0);
                2:       fm_rdy = ($urandom_range(0, 2) != 0);
                default: fm_rdy = 1'b0;
            endcase
            for (int i = 0; i < N; i++) begin
                sb_req[i]           = (rem[i] > 0) || hold_req[i];
                sb_vld[i]           = (rem[i] > 0);
                sb_data[i*DW +: DW] = mkdata(i, seq[i]);
                sb_last[i]          = (rem[i] > 0) && (plen[i] != 0) && ((pos[i] % plen[i]) == plen[i] - 1);
            end
            #1;
            chk("rdy_onehot0", v_t'($onehot0(sb_rdy)), v_t'(1));
            if (fm_out[0] && fm_rdy) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", v_t'(fm_out[DW:1]), v_t'(0));
                end else begin
                    e = expq.pop_front();
                    chk("beat_data", v_t'(fm_out[DW:1]), v_t'(e.d));
                    chk("beat_last", v_t'(fm_last), v_t'(e.l));
                end
                beats_out++;
                if (fm_last) lasts_out++;
            end
            if (oversize_err) begin
                ovs_seen++;
                chk("ovs_with_last_beat", v_t'(fm_out[0] && fm_last), v_t'(1));
            end
            if (timeout_err) begin
                to_seen++;
                to_cyc  = cyc;
                to_busy = busy;
            end
            acc = sb_vld & sb_rdy;
            @(posedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if (i != cur_src) gcnt = 0;
                    cur_src = i;
                    gcnt++;
                    e.d   = mkdata(i, seq[i]);
                    e.l   = ((plen[i] != 0) && ((pos[i] % plen[i]) == plen[i] - 1)) || (gcnt == MAXW);
                    e.src = i;
                    if (pkt_start) grant_log.push_back(i);
                    pkt_start = e.l;
                    if (e.l) gcnt = 0;
                    expq.push_back(e);
                    last_acc_cyc[i] = cyc;
                    rem[i]--;
                    pos[i]++;
                    seq[i]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Wait until the masked sources are empty and the output has drained.
    task automatic wait_idle(input logic [N-1:0] m, input int maxc, input string nm);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            tick();
            n++;
            done = (expq.size() == 0) && !busy && !fm_out[0];
            for (int i = 0; i < N; i++) if (m[i] && rem[i] != 0) done = 1'b0;
        end
        chk({"drain_", nm}, v_t'(done), v_t'(1));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : test
        vec_t tbl[6];
        int   b0, l0, o0, t0, n;

        tbl[0] = '{src: 3,  len: 8,   md: 1, e_beats: 8,   e_lasts: 1, e_ovs: 0};
        tbl[1] = '{src: 7,  len: 70,  md: 0, e_beats: 70,  e_lasts: 2, e_ovs: 1};
        tbl[2] = '{src: 28, len: 1,   md: 0, e_beats: 1,   e_lasts: 1, e_ovs: 0};
        tbl[3] = '{src: 12, len: 65,  md: 2, e_beats: 65,  e_lasts: 2, e_ovs: 1};
        tbl[4] = '{src: 16, len: 63,  md: 1, e_beats: 63,  e_lasts: 1, e_ovs: 0};
        tbl[5] = '{src: 20, len: 130, md: 2, e_beats: 130, e_lasts: 3, e_ovs: 2};

        // Reset held with every buffer requesting.
        rst      = 1'b1;
        enable   = 1'b0;
        hold_req = '1;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #3;
            chk("rst_sb_rdy", v_t'(sb_rdy), v_t'(0));
            chk("rst_fm_out", fm_out, v_t'(0));
            chk("rst_ctl", v_t'({fm_last, grant_idx, busy, timeout_err, oversize_err}), v_t'(0));
        end
        tick();
        hold_req = '0;
        tick();
        rst = 1'b0;
        tick();

        // Round robin: three buffers with back-to-back 3-beat packets.
        b0 = beats_out; l0 = lasts_out;
        foreach (rem[i]) begin rem[i] = 0; plen[i] = 0; pos[i] = 0; end
        rem[0] = 6;  plen[0] = 3;
        rem[5] = 6;  plen[5] = 3;
        rem[28] = 6; plen[28] = 3;
        grant_log.delete();
        pkt_start = 1'b1;
        enable    = 1'b1;
        wait_idle('1, 500, "rr");
        chk("rr_log_size", v_t'(grant_log.size() >= 4), v_t'(1));
        if (grant_log.size() >= 4) begin
            chk("rr_grant0", v_t'(grant_log[0]), v_t'(0));
            chk("rr_grant1", v_t'(grant_log[1]), v_t'(5));
            chk("rr_grant2", v_t'(grant_log[2]), v_t'(28));
            chk("rr_grant3", v_t'(grant_log[3]), v_t'(0));
        end
        chk("rr_beats", v_t'(beats_out - b0), v_t'(18));
        chk("rr_lasts", v_t'(lasts_out - l0), v_t'(6));

        // Single-source transfers under several link patterns.
        for (int t = 0; t < 6; t++) begin
            b0 = beats_out; l0 = lasts_out; o0 = ovs_seen; t0 = to_seen;
            mode = tbl[t].md;
            pos[tbl[t].src]  = 0;
            plen[tbl[t].src] = tbl[t].len;
            rem[tbl[t].src]  = tbl[t].len;
            wait_idle('1, 2000, $sformatf("vec%0d", t));
            chk($sformatf("vec%0d_beats", t), v_t'(beats_out - b0), v_t'(tbl[t].e_beats));
            chk($sformatf("vec%0d_lasts", t), v_t'(lasts_out - l0), v_t'(tbl[t].e_lasts));
            chk($sformatf("vec%0d_ovs", t), v_t'(ovs_seen - o0), v_t'(tbl[t].e_ovs));
            chk($sformatf("vec%0d_gidx", t), v_t'(grant_idx), v_t'(tbl[t].src));
            chk($sformatf("vec%0d_no_to", t), v_t'(to_seen - t0), v_t'(0));
        end
        mode = 0;

        // Enable dropped while SB1 is mid-packet.
        b0 = beats_out; l0 = lasts_out;
        pos[1] = 0; plen[1] = 10; rem[1] = 10;
        n = 0;
        while (!(busy && grant_idx == IW'(1)) && n < 50) begin tick(); n++; end
        chk("en_grant_sb1", v_t'(grant_idx), v_t'(1));
        enable = 1'b0;
        pos[9] = 0; plen[9] = 3; rem[9] = 3;
        wait_idle(N'(2), 200, "en_sb1");
        chk("en_sb1_beats", v_t'(beats_out - b0), v_t'(10));
        chk("en_sb1_lasts", v_t'(lasts_out - l0), v_t'(1));
        repeat (20) tick();
        chk("en_hold_rem9", v_t'(rem[9]), v_t'(3));
        chk("en_hold_busy", v_t'(busy), v_t'(0));
        enable = 1'b1;
        wait_idle('1, 200, "en_sb9");
        chk("en_sb9_gidx", v_t'(grant_idx), v_t'(9));
        chk("en_total_lasts", v_t'(lasts_out - l0), v_t'(2));

        // Timeout: SB2 sends one beat then goes quiet while still requesting.
        l0 = lasts_out; t0 = to_seen; o0 = ovs_seen;
        pos[2] = 0; plen[2] = 0; rem[2] = 1;
        hold_req[2] = 1'b1;
        n = 0;
        while (!(busy && grant_idx == IW'(2)) && n < 50) begin tick(); n++; end
        chk("to_grant_sb2", v_t'(grant_idx), v_t'(2));
        pos[4] = 0; plen[4] = 2; rem[4] = 2;
        n = 0;
        while (to_seen == t0 && n < TOUT + 200) begin tick(); n++; end
        hold_req[2] = 1'b0;
        chk("to_pulse", v_t'(to_seen - t0), v_t'(1));
        chk("to_latency", v_t'(to_cyc - last_acc_cyc[2]), v_t'(TOUT));
        chk("to_busy_low", v_t'(to_busy), v_t'(0));
        wait_idle('1, 200, "to_sb4");
        chk("to_next_gidx", v_t'(grant_idx), v_t'(4));
        chk("to_lasts", v_t'(lasts_out - l0), v_t'(1));
        chk("to_no_ovs", v_t'(ovs_seen - o0), v_t'(0));
        chk("sb_empty", v_t'(expq.size()), v_t'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
